// File: rtl/cla_pkg.sv
// Shared constants and elaboration helpers for the pipelined CLA adder.
// Offsets locate each stage's registers inside the triangular stage buses.
package cla_pkg;

    localparam int GROUP_W = 4;

    function automatic int num_stages(input int width, input int gps);
        return width / (GROUP_W * gps);
    endfunction

    function automatic bit width_ok(input int width, input int gps);
        return (gps > 0) && (width > 0) && ((width % (GROUP_W * gps)) == 0);
    endfunction

    // Stage j keeps width - j*sw unconsumed operand bits.
    function automatic int op_off(input int j, input int width, input int sw);
        int acc;
        acc = 0;
        for (int i = 1; i < j; i++) acc += width - i * sw;
        return acc;
    endfunction

    // Stage j keeps j*sw finished low sum bits.
    function automatic int lo_off(input int j, input int sw);
        int acc;
        acc = 0;
        for (int i = 1; i < j; i++) acc += i * sw;
        return acc;
    endfunction

endpackage

// File: rtl/cla4_group.sv
// One 4-bit carry-lookahead group with full lookahead carries.
// Exposes the carry into bit 3 so the top group can form signed overflow.
module cla4_group
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] s,
    output logic               cout,
    output logic               c3
);

    logic [GROUP_W-1:0] g;
    logic [GROUP_W-1:0] p;
    logic [GROUP_W:0]   c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        s    = p ^ c[GROUP_W-1:0];
        cout = c[GROUP_W];
        c3   = c[GROUP_W-1];
    end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Each stage resolves GROUPS_PER_STAGE lookahead groups; one shared advance enable.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int GROUPS_PER_STAGE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int GPS = GROUPS_PER_STAGE;
    localparam int SW  = GROUP_W * GPS;
    localparam int NS  = num_stages(WIDTH, GPS);
    localparam int OPW = (NS > 1) ? op_off(NS, WIDTH, SW) : 1;
    localparam int LOW = (NS > 1) ? lo_off(NS, SW) : 1;

    if (!width_ok(WIDTH, GPS)) begin : g_bad_width
        $error("WIDTH must be a multiple of 4*GROUPS_PER_STAGE");
    end

    logic             adv;
    logic [WIDTH-1:0] b_cond;
    logic [OPW-1:0]   a_bus;
    logic [OPW-1:0]   b_bus;
    logic [LOW-1:0]   lo_bus;
    logic [NS-1:0]    c_bus;
    logic [NS-1:0]    v_bus;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             valid_q;

    assign adv      = !valid_q || out_ready;
    assign in_ready = adv;
    assign b_cond   = in_sub ? ~in_b : in_b;
    assign c_bus[0] = in_sub | in_cin;
    assign v_bus[0] = in_valid;

    for (genvar k = 1; k <= NS; k++) begin : g_stage
        localparam int RW = WIDTH - (k - 1) * SW;

        logic [RW-1:0]  a_i;
        logic [RW-1:0]  b_i;
        logic [SW-1:0]  s_w;
        logic [GPS:0]   gc;
        logic [GPS-1:0] gc3;
        logic           v_i;

        assign gc[0] = c_bus[k-1];
        assign v_i   = v_bus[k-1];

        if (k == 1) begin : g_src_in
            assign a_i = in_a;
            assign b_i = b_cond;
        end else begin : g_src_reg
            assign a_i = a_bus[op_off(k-1, WIDTH, SW) +: RW];
            assign b_i = b_bus[op_off(k-1, WIDTH, SW) +: RW];
        end

        // Ripple between groups inside a stage, lookahead within each group.
        for (genvar g = 0; g < GPS; g++) begin : g_grp
            cla4_group u_grp (
                .a    (a_i[g*GROUP_W +: GROUP_W]),
                .b    (b_i[g*GROUP_W +: GROUP_W]),
                .cin  (gc[g]),
                .s    (s_w[g*GROUP_W +: GROUP_W]),
                .cout (gc[g+1]),
                .c3   (gc3[g])
            );
        end

        if (k < NS) begin : g_mid
            localparam int LW = k * SW;

            logic [RW-SW-1:0] a_d, a_q, b_d, b_q;
            logic [LW-1:0]    lo_d, lo_q, lo_new;
            logic             c_d, c_q, v_d, v_q;

            if (k == 1) begin : g_lo_first
                assign lo_new = s_w;
            end else begin : g_lo_more
                assign lo_new = {s_w, lo_bus[lo_off(k-1, SW) +: (k-1)*SW]};
            end

            always_comb begin
                a_d  = a_q;
                b_d  = b_q;
                lo_d = lo_q;
                c_d  = c_q;
                v_d  = v_q;
                if (adv) begin
                    v_d = v_i;
                    if (v_i) begin
                        a_d  = a_i[RW-1:SW];
                        b_d  = b_i[RW-1:SW];
                        lo_d = lo_new;
                        c_d  = gc[GPS];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q  <= '0;
                    b_q  <= '0;
                    lo_q <= '0;
                    c_q  <= 1'b0;
                    v_q  <= 1'b0;
                end else begin
                    a_q  <= a_d;
                    b_q  <= b_d;
                    lo_q <= lo_d;
                    c_q  <= c_d;
                    v_q  <= v_d;
                end
            end

            assign a_bus[op_off(k, WIDTH, SW) +: RW-SW] = a_q;
            assign b_bus[op_off(k, WIDTH, SW) +: RW-SW] = b_q;
            assign lo_bus[lo_off(k, SW) +: LW]          = lo_q;
            assign c_bus[k]                             = c_q;
            assign v_bus[k]                             = v_q;
        end else begin : g_last
            logic [WIDTH-1:0] sum_d, sum_new;
            logic             cout_d, ovf_d, valid_d;

            if (k == 1) begin : g_sum_first
                assign sum_new = s_w;
            end else begin : g_sum_more
                assign sum_new = {s_w, lo_bus[lo_off(k-1, SW) +: (k-1)*SW]};
            end

            // Outputs only change when a valid beat lands.
            always_comb begin
                sum_d   = sum_q;
                cout_d  = cout_q;
                ovf_d   = ovf_q;
                valid_d = valid_q;
                if (adv) begin
                    valid_d = v_i;
                    if (v_i) begin
                        sum_d  = sum_new;
                        cout_d = gc[GPS];
                        ovf_d  = gc3[GPS-1] ^ gc[GPS];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_q   <= '0;
                    cout_q  <= 1'b0;
                    ovf_q   <= 1'b0;
                    valid_q <= 1'b0;
                end else begin
                    sum_q   <= sum_d;
                    cout_q  <= cout_d;
                    ovf_q   <= ovf_d;
                    valid_q <= valid_d;
                end
            end
        end
    end

    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed and random checks of pipelined_cla_adder against an arithmetic model.
// Results are checked in order from a queue of expected {cout, ovf, sum}.
module tb_pipelined_cla_adder;

    localparam int W  = 16;
    localparam int NS = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_cin = 1'b0;
    logic         in_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int lat;
    int gap;

    logic [17:0] exp_q[$];
    int          del_cyc[$];

    pipelined_cla_adder #(.WIDTH(W), .GROUPS_PER_STAGE(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total = n_total + 1;
        assert (got === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // {cout, ovf, sum} from plain two's-complement arithmetic.
    function automatic logic [17:0] ref_op(input logic [W-1:0] a, b,
                                           input logic cin, sub);
        logic [W:0]   full;
        logic [W-1:0] bb;
        logic         ovf;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : cin)};
        ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return {full[W], ovf, full[W-1:0]};
    endfunction

    task automatic step(input logic v, input logic [W-1:0] a, b,
                        input logic cin, sub, input logic ordy);
        logic [17:0] e;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_sub    = sub;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result", 32'({out_cout, out_ovf, out_sum}), 32'(e));
                del_cyc.push_back(cyc);
            end
        end
        if (in_valid && in_ready) exp_q.push_back(ref_op(a, b, cin, sub));
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, '0, '0, 1'b0, 1'b0, ordy);
    endtask

    task automatic drain(output int l);
        l = 0;
        while (!out_valid && l < 20) begin
            idle(1'b1);
            l++;
        end
    endtask

    task automatic flush();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 60) begin
            idle(1'b1);
            n++;
        end
        chk("flush_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // Asynchronous reset with no clock edge in between.
        #3 rst_n = 1'b0;
        #1;
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_sum", 32'(out_sum), 32'h0000);
        chk("reset_ready", 32'(in_ready), 32'd1);
        chk("reset_flags", 32'({out_cout, out_ovf}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        drain(lat);
        chk("add_latency", 32'(lat), 32'(NS - 1));
        chk("add_carry", 32'({out_cout, out_ovf, out_sum}), 32'h20000);
        idle(1'b1);

        step(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
        drain(lat);
        chk("sub_latency", 32'(lat), 32'(NS - 1));
        chk("sub_ovf", 32'({out_cout, out_ovf, out_sum}), 32'h37FFF);
        idle(1'b1);

        step(1'b1, 16'h0003, 16'h0005, 1'b1, 1'b1, 1'b1);
        drain(lat);
        chk("sub_borrow", 32'({out_cout, out_ovf, out_sum}), 32'h0FFFE);
        idle(1'b1);

        // Eight back-to-back beats must come out on eight consecutive cycles.
        del_cyc.delete();
        for (int i = 0; i < 8; i++)
            step(1'b1, 16'(i * 16'h1111), 16'h0F0F, 1'(i & 1), 1'b0, 1'b1);
        flush();
        chk("stream_count", 32'(del_cyc.size()), 32'd8);
        gap = (del_cyc.size() == 8) ? del_cyc[7] - del_cyc[0] : -1;
        chk("stream_gap", 32'(gap), 32'd7);

        // Fill the pipeline with the consumer stalled, then hold.
        del_cyc.delete();
        for (int i = 0; i < NS; i++)
            step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 1'b0);
        chk("bp_full_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            out_ready = 1'b0;
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_frozen", 32'({out_cout, out_ovf, out_sum}), 32'(exp_q[0]));
            step(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'($urandom), 1'b0);
        end
        for (int i = 0; i < 4; i++)
            step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        flush();
        chk("bp_delivered", 32'(del_cyc.size()), 32'd8);

        // Reset with three beats in flight discards them all.
        for (int i = 0; i < 3; i++)
            step(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("mf_reset_valid", 32'(out_valid), 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        del_cyc.delete();
        repeat (6) idle(1'b1);
        chk("mf_no_out", 32'(del_cyc.size()), 32'd0);
        chk("mf_valid_low", 32'(out_valid), 32'd0);
        step(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1);
        drain(lat);
        chk("mf_latency", 32'(lat), 32'(NS - 1));
        idle(1'b1);
        chk("mf_delivered", 32'(del_cyc.size()), 32'd1);

        // Random traffic with random backpressure and bubbles.
        for (int i = 0; i < 80; i++)
            step(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                 1'($urandom), ($urandom_range(0, 3) != 0));
        flush();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
